// File: rtl/spi_settings_responder.sv
// rtl/spi_settings_responder.sv - SPI responder bridging master frames to settings-bus writes and readbacks
module spi_settings_responder #(
    parameter int AWIDTH      = 8,
    parameter int DWIDTH      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int RB_LATENCY  = 1
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              spi_sen,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              set_stb,
    output logic [AWIDTH-1:0] set_addr,
    output logic [DWIDTH-1:0] set_data,
    output logic              rb_stb,
    output logic [AWIDTH-1:0] rb_addr,
    input  logic [DWIDTH-1:0] rb_data,
    output logic              busy,
    output logic [7:0]        abort_cnt
);

    localparam int FRAME_BITS = 16 + DWIDTH;
    localparam int CW         = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] HDR_LAST   = CW'(15);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);
    localparam logic [1:0]    RB_WAIT    = 2'(RB_LATENCY);

    typedef enum logic [2:0] {
        ARMWAIT,
        IDLE,
        HDR,
        WDATA,
        RWAIT,
        RDATA,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sen_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_last;
    logic [CW-1:0]          bit_cnt;
    logic [14:0]            hdr_sr;
    logic [DWIDTH-1:0]      data_sr;
    logic [1:0]             wait_cnt;

    logic              sen_s;
    logic              sclk_s;
    logic              mosi_s;
    logic              sclk_rise;
    logic              sclk_fall;
    logic [15:0]       hdr_next;
    logic [DWIDTH-1:0] data_next;

    // Sync flops clear to 0 so a reset during a live frame stays in ARMWAIT until sen really goes high.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            sen_sync  <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_last <= 1'b0;
        end else begin
            sen_sync  <= {sen_sync[SYNC_STAGES-2:0], spi_sen};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_last <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sen_s     = sen_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_last;
    assign sclk_fall = ~sclk_s & sclk_last;
    assign hdr_next  = {hdr_sr, mosi_s};
    assign data_next = {data_sr[DWIDTH-2:0], mosi_s};

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state     <= ARMWAIT;
            bit_cnt   <= '0;
            hdr_sr    <= '0;
            data_sr   <= '0;
            wait_cnt  <= '0;
            spi_miso  <= 1'b0;
            set_stb   <= 1'b0;
            set_addr  <= '0;
            set_data  <= '0;
            rb_stb    <= 1'b0;
            rb_addr   <= '0;
            busy      <= 1'b0;
            abort_cnt <= '0;
        end else begin
            set_stb <= 1'b0;
            rb_stb  <= 1'b0;
            // sen high ends any frame; anything short of DONE counts as an abort.
            if (sen_s && state != ARMWAIT && state != IDLE) begin
                state    <= IDLE;
                busy     <= 1'b0;
                spi_miso <= 1'b0;
                if (state != DONE && abort_cnt != 8'hFF) begin
                    abort_cnt <= abort_cnt + 8'd1;
                end
            end else begin
                case (state)
                    ARMWAIT: begin
                        if (sen_s) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        spi_miso <= 1'b0;
                        if (!sen_s) begin
                            state   <= HDR;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    HDR: begin
                        if (sclk_rise) begin
                            hdr_sr  <= hdr_next[14:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == HDR_LAST) begin
                                if (hdr_next[15]) begin
                                    rb_stb   <= 1'b1;
                                    rb_addr  <= hdr_next[AWIDTH-1:0];
                                    wait_cnt <= '0;
                                    state    <= RWAIT;
                                end else begin
                                    state <= WDATA;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            data_sr <= data_next;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == FRAME_LAST) begin
                                set_stb  <= 1'b1;
                                set_addr <= hdr_sr[AWIDTH-1:0];
                                set_data <= data_next;
                                state    <= DONE;
                            end
                        end
                    end
                    RWAIT: begin
                        if (wait_cnt == RB_WAIT) begin
                            data_sr <= rb_data;
                            state   <= RDATA;
                        end else begin
                            wait_cnt <= wait_cnt + 2'd1;
                        end
                    end
                    RDATA: begin
                        if (sclk_fall) begin
                            spi_miso <= data_sr[DWIDTH-1];
                            data_sr  <= {data_sr[DWIDTH-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == FRAME_LAST) begin
                                spi_miso <= 1'b0;
                                state    <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= ARMWAIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_settings_responder.sv
// tb/tb_spi_settings_responder.sv - randomized bench for spi_settings_responder against a frame-level model
`timescale 1ns/1ps
module tb_spi_settings_responder;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int SS   = 2;
    localparam int RBL  = 1;
    localparam int HALF = 8;
    localparam int GAP  = 10;
    localparam int MIN_GAP = SS + 2;

    logic          bus_clk = 1'b0;
    logic          bus_rst_n;
    logic          spi_sen;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_miso;
    logic          set_stb;
    logic [AW-1:0] set_addr;
    logic [DW-1:0] set_data;
    logic          rb_stb;
    logic [AW-1:0] rb_addr;
    logic [DW-1:0] rb_data;
    logic          busy;
    logic [7:0]    abort_cnt;

    spi_settings_responder #(
        .AWIDTH(AW), .DWIDTH(DW), .SYNC_STAGES(SS), .RB_LATENCY(RBL)
    ) dut (
        .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
        .spi_sen(spi_sen), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rb_stb(rb_stb), .rb_addr(rb_addr), .rb_data(rb_data),
        .busy(busy), .abort_cnt(abort_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] regs [0:255];
    logic [3:0]  rb_hist = '0;
    logic        set_stb_q = 1'b0;
    logic        rb_stb_q = 1'b0;
    int          wr_cnt = 0;
    int          rb_cnt = 0;
    int          long_pulses = 0;

    int          exp_wr = 0;
    int          exp_rb = 0;
    int          exp_abort = 0;
    logic [7:0]  exp_waddr = '0;
    logic [31:0] exp_wdata = '0;
    logic [7:0]  exp_raddr = '0;

    // Readback responder: data is only meaningful RBL cycles after rb_stb, noise otherwise.
    always @(negedge bus_clk) begin
        rb_hist = {rb_hist[2:0], rb_stb};
        rb_data = rb_hist[RBL] ? regs[rb_addr] : $urandom;
        if (set_stb) wr_cnt++;
        if (rb_stb) rb_cnt++;
        if ((set_stb && set_stb_q) || (rb_stb && rb_stb_q)) long_pulses++;
        set_stb_q = set_stb;
        rb_stb_q  = rb_stb;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge bus_clk);
    endtask

    task automatic spi_xfer(input logic [47:0] frame, input int nbits, input int gap,
                            output logic [47:0] cap);
        cap = '0;
        spi_sen = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 48) ? frame[47-i] : 1'($urandom);
            cycles(HALF);
            if (i == 0) chk("busy_in_frame", busy, 1);
            if (i < 48) cap[47-i] = spi_miso;
            spi_sclk = 1'b1;
            cycles(HALF);
            spi_sclk = 1'b0;
        end
        cycles(HALF);
        spi_sen  = 1'b1;
        spi_mosi = 1'b0;
        cycles(gap);
    endtask

    task automatic do_frame(input bit rnw, input logic [7:0] addr, input logic [31:0] data,
                            input int nbits, input int gap);
        logic [47:0] cap;
        logic [47:0] frame;
        frame = {rnw, 7'($urandom), addr, data};
        spi_xfer(frame, nbits, gap, cap);
        if (nbits >= 48) begin
            if (rnw) begin
                exp_rb++;
                exp_raddr = addr;
                chk("miso_readback", cap[31:0], regs[addr]);
            end else begin
                exp_wr++;
                exp_waddr = addr;
                exp_wdata = data;
            end
        end else begin
            if (exp_abort < 255) exp_abort++;
            if (rnw && nbits >= 16) begin
                exp_rb++;
                exp_raddr = addr;
            end
        end
    endtask

    task automatic check_state(input string tag);
        cycles(2);
        chk({tag, "_wr_cnt"}, wr_cnt, exp_wr);
        chk({tag, "_rb_cnt"}, rb_cnt, exp_rb);
        chk({tag, "_abort"}, abort_cnt, exp_abort);
        chk({tag, "_set_addr"}, set_addr, exp_waddr);
        chk({tag, "_set_data"}, set_data, exp_wdata);
        chk({tag, "_rb_addr"}, rb_addr, exp_raddr);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_miso"}, spi_miso, 0);
    endtask

    initial begin
        logic [47:0] cap;
        for (int i = 0; i < 256; i++) regs[i] = $urandom;
        regs[5] = 32'hA5C3_0F81;
        bus_rst_n = 1'b0;
        spi_sen   = 1'b1;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        cycles(5);
        chk("rst_set_stb", set_stb, 0);
        chk("rst_rb_stb", rb_stb, 0);
        chk("rst_set_addr", set_addr, 0);
        chk("rst_set_data", set_data, 0);
        chk("rst_rb_addr", rb_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort_cnt, 0);
        chk("rst_miso", spi_miso, 0);
        bus_rst_n = 1'b1;
        cycles(10);

        do_frame(1'b0, 8'h28, 32'hDEADBEEF, 48, GAP);
        check_state("write");
        do_frame(1'b1, 8'h05, 32'h0, 48, GAP);
        check_state("read");

        do_frame(1'b0, 8'h33, 32'h1234_5678, 30, GAP);
        check_state("abort");
        do_frame(1'b0, 8'h34, 32'h8765_4321, 48, GAP);
        check_state("after_abort");

        fork
            spi_xfer({1'b0, 7'h0, 8'h77, 32'hCAFE_F00D}, 48, GAP, cap);
            begin
                cycles(20 * 2 * HALF + HALF / 2);
                bus_rst_n = 1'b0;
                cycles(3);
                bus_rst_n = 1'b1;
                cycles(1);
                chk("midrst_set_addr", set_addr, 0);
                chk("midrst_set_data", set_data, 0);
                chk("midrst_abort", abort_cnt, 0);
                chk("midrst_busy", busy, 0);
            end
        join
        exp_abort = 0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_raddr = '0;
        check_state("midrst");
        do_frame(1'b0, 8'h41, 32'h0BAD_CAFE, 48, GAP);
        check_state("after_rst");

        do_frame(1'b0, 8'h5A, 32'hFEED_FACE, 56, MIN_GAP);
        do_frame(1'b1, 8'h05, 32'hFFFF_FFFF, 48, GAP);
        check_state("b2b");

        for (int k = 0; k < 20; k++) begin
            int len;
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 47);
                1:       len = $urandom_range(49, 56);
                default: len = 48;
            endcase
            do_frame(1'($urandom), 8'($urandom), $urandom, len, GAP);
            check_state("rand");
        end

        for (int k = 0; k < 260; k++) do_frame(1'b0, 8'($urandom), $urandom, 1, MIN_GAP);
        check_state("sat");
        chk("sat_ff", abort_cnt, 8'hFF);
        chk("stb_one_cycle", long_pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
